// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: scalar aliases (common_pkg) and the
// pipeline records, op codes and FSM state enum (pipes_pkg).
package common_pkg;
  typedef logic        u1;
  typedef logic [63:0] u64;
endpackage

package pipes_pkg;
  import common_pkg::*;

  // FLUSH is zero so an all-zero record is a bubble.
  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    ALU   = 2'd1,
    HALT  = 2'd2
  } op_t;

  typedef struct packed {
    u64          pc;
    op_t         op;
    logic [4:0]  dst;
    u64          result;
    u1           wen;
  } memory_data_t;

  typedef struct packed {
    u64          pc;
    op_t         op;
    logic [4:0]  dst;
    u64          result;
    u1           wen;
  } writeback_data_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

  localparam writeback_data_t WB_BUBBLE = '0;

  function automatic writeback_data_t to_wb(input memory_data_t m);
    writeback_data_t w;
    w.pc     = m.pc;
    w.op     = m.op;
    w.dst    = m.dst;
    w.result = m.result;
    w.wen    = m.wen;
    return w;
  endfunction
endpackage

// File: rtl/writeback_stage_fifo.sv
// wb_skid_fifo: 2-entry FIFO holding memory-stage records while the
// register-file port is stalled. Pointers are 1 bit and wrap at 2.
module wb_skid_fifo
  import pipes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  memory_data_t din,
  output memory_data_t head,
  output logic         full,
  output logic         empty
);
  memory_data_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Storage: data only, no reset needed because count gates its use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; clear drops everything held.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM->WB pipeline register and commit producer.
// Emits one writeback_data_t per cycle on dataW (op FLUSH = bubble), drives
// the register-file write port, counts retired instructions and freezes on
// HALT until reset.
// Optional feature macro WB_SKID_EN: 2-entry skid FIFO plus rf_stall input.
//
// Handshake: dataM transfers on a rising edge when valid_m && ready_w.
// ready_w depends only on registered state (FSM state, FIFO occupancy), never
// on valid_m; a same-cycle flush drops the offered record.
module writeback_stage
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef WB_SKID_EN
  input  logic                     rf_stall,
`endif
  input  memory_data_t             dataM,
  input  logic                     valid_m,
  output logic                     ready_w,
  input  logic                     flush,
  output writeback_data_t          dataW,
  output logic                     rf_wen,
  output logic [$clog2(NREG)-1:0]  rf_waddr,
  output logic [63:0]              rf_wdata,
  output logic [CNT_W-1:0]         instret,
  output logic                     halted
);
  wb_state_t        state_q, state_d;
  logic             buf_full;
  logic             advance;      // output register loads a new record
  logic             push;         // handshake transfer this cycle
  logic             take;         // a real record moves into dataW
  memory_data_t     cand;         // record that would move into dataW
  logic             cand_valid;
  writeback_data_t  data_w_d;
  logic             rf_wen_q, rf_wen_d;
  logic [CNT_W-1:0] instret_d;

  assign ready_w = (state_q == RUN) && !buf_full;
  assign push    = valid_m && ready_w && !flush;
  assign halted  = (state_q == HALTED);

`ifdef WB_SKID_EN
  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  memory_data_t fifo_head;

  // A stalled port holds dataW; an empty FIFO lets the input bypass straight
  // into dataW so the unstalled latency stays at one cycle.
  assign advance    = !rf_stall;
  assign buf_full   = fifo_full;
  assign cand       = fifo_empty ? dataM : fifo_head;
  assign cand_valid = fifo_empty ? push : 1'b1;
  assign fifo_pop   = take && !fifo_empty;
  assign fifo_push  = push && !(take && fifo_empty);
  assign rf_wen     = rf_wen_q && !rf_stall;

  wb_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush && (state_q == RUN)),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (dataM),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  // Single entry that drains every cycle, so it is never full.
  assign advance    = 1'b1;
  assign buf_full   = 1'b0;
  assign cand       = dataM;
  assign cand_valid = push;
  assign rf_wen     = rf_wen_q;
`endif

  assign take     = advance && cand_valid && !flush && (state_q == RUN);
  assign rf_waddr = dataW.dst;
  assign rf_wdata = dataW.result;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state, next output record and retire count.
  always_comb begin
    state_d   = state_q;
    data_w_d  = dataW;
    rf_wen_d  = rf_wen_q;
    instret_d = instret + CNT_W'(advance && (dataW.op != FLUSH));
    if (advance) begin
      data_w_d = WB_BUBBLE;
      rf_wen_d = 1'b0;
      if (take) begin
        data_w_d = to_wb(cand);
        rf_wen_d = (cand.op != FLUSH) && cand.wen && (cand.dst != 5'd0);
        if (cand.op == HALT) state_d = HALTED;
      end
    end
  end

  // Output register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataW    <= WB_BUBBLE;
      rf_wen_q <= 1'b0;
      instret  <= '0;
    end else begin
      dataW    <= data_w_d;
      rf_wen_q <= rf_wen_d;
      instret  <= instret_d;
    end
  end
endmodule
